// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS memory-bus arbiter.
package mips_bus_pkg;

   // Arbiter state: idle, or a transfer on the bus owned by fetch / data.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } arb_state_t;

   // Owner of the most recent grant, used for round-robin tie-break.
   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;

   // Fetches always read the full word.
   localparam logic [3:0] BE_ALL = 4'b1111;

endpackage

// File: rtl/mips_bus_arbiter.sv
// Two-requester (fetch / data) arbiter onto a single Avalon-style memory bus.
// One transfer at a time, bus outputs registered, round-robin on ties.
module mips_bus_arbiter
   import mips_bus_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  reset,

   input  logic [ADDR_W-1:0]     i_address,
   input  logic                  i_read,
   output logic                  i_waitrequest,
   output logic [DATA_W-1:0]     i_readdata,

   input  logic [ADDR_W-1:0]     d_address,
   input  logic                  d_read,
   input  logic                  d_write,
   input  logic [DATA_W-1:0]     d_writedata,
   input  logic [DATA_W/8-1:0]   d_byteenable,
   output logic                  d_waitrequest,
   output logic [DATA_W-1:0]     d_readdata,

   output logic [ADDR_W-1:0]     address,
   output logic                  read,
   output logic                  write,
   output logic [DATA_W-1:0]     writedata,
   output logic [DATA_W/8-1:0]   byteenable,
   input  logic                  waitrequest,
   input  logic [DATA_W-1:0]     readdata
);

   localparam int unsigned BE_W = DATA_W / 8;

   arb_state_t             state_q,      state_d;
   owner_t                 last_owner_q, last_owner_d;
   logic [ADDR_W-1:0]      address_q,    address_d;
   logic                   read_q,       read_d;
   logic                   write_q,      write_d;
   logic [DATA_W-1:0]      writedata_q,  writedata_d;
   logic [BE_W-1:0]        byteenable_q, byteenable_d;

   logic                   i_req;
   logic                   d_req;
   logic                   done;
   logic                   done_i;
   logic                   done_d;
   logic                   grant_i;
   logic                   grant_d;

   // Request and completion decode.
   assign i_req  = i_read;
   assign d_req  = d_read | d_write;
   assign done   = (state_q != IDLE) && (read_q || write_q) && !waitrequest;
   assign done_i = done && (state_q == BUSY_I);
   assign done_d = done && (state_q == BUSY_D);

   // Grant selection: IDLE uses round-robin on ties; on completion only the
   // other port may be granted, so the finishing port's held request is consumed.
   always_comb begin
      grant_i = 1'b0;
      grant_d = 1'b0;
      case (state_q)
         IDLE: begin
            grant_i = i_req && (!d_req || (last_owner_q == OWN_D));
            grant_d = d_req && !grant_i;
         end
         BUSY_I:  grant_d = done_i && d_req;
         BUSY_D:  grant_i = done_d && i_req;
         default: begin
            grant_i = 1'b0;
            grant_d = 1'b0;
         end
      endcase
   end

   // Next-state and bus-register update; bus holds until a grant or completion.
   always_comb begin
      state_d      = state_q;
      last_owner_d = last_owner_q;
      address_d    = address_q;
      read_d       = read_q;
      write_d      = write_q;
      writedata_d  = writedata_q;
      byteenable_d = byteenable_q;

      if (grant_i) begin
         state_d      = BUSY_I;
         last_owner_d = OWN_I;
         address_d    = i_address;
         read_d       = 1'b1;
         write_d      = 1'b0;
         writedata_d  = '0;
         byteenable_d = BE_W'(BE_ALL);
      end else if (grant_d) begin
         state_d      = BUSY_D;
         last_owner_d = OWN_D;
         address_d    = d_address;
         // A simultaneous read+write request is treated as a write.
         read_d       = d_read && !d_write;
         write_d      = d_write;
         writedata_d  = d_writedata;
         byteenable_d = d_byteenable;
      end else if (done) begin
         state_d      = IDLE;
         read_d       = 1'b0;
         write_d      = 1'b0;
      end
   end

   // State and bus registers; reset drops any transfer in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         last_owner_q <= OWN_D;
         address_q    <= '0;
         read_q       <= 1'b0;
         write_q      <= 1'b0;
         writedata_q  <= '0;
         byteenable_q <= '0;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         address_q    <= address_d;
         read_q       <= read_d;
         write_q      <= write_d;
         writedata_q  <= writedata_d;
         byteenable_q <= byteenable_d;
      end
   end

   // Memory bus driven straight from the registers.
   assign address    = address_q;
   assign read       = read_q;
   assign write      = write_q;
   assign writedata  = writedata_q;
   assign byteenable = byteenable_q;

   // Requester handshakes release only in the owner's completion cycle.
   assign i_waitrequest = !done_i;
   assign d_waitrequest = !done_d;
   assign i_readdata    = (done_i && read_q) ? readdata : '0;
   assign d_readdata    = (done_d && read_q) ? readdata : '0;

endmodule
